// File: rtl/exu_lsu_mem_if.sv
// exu_lsu_mem_if
//   Memory-side channel of the EXU load/store unit. It carries a valid/ready
//   request channel and a response channel. The response channel has no ready
//   signal.
//   master : the LSU. It drives the request and receives ready and response.
//   slave  : the memory. It drives ready and response and receives the request.
//   Signals:
//     lsu_mem_req_vld    request valid
//     mem_lsu_req_rdy    request ready
//     lsu_mem_req_wr     1 = store
//     lsu_mem_req_addr   word-aligned address
//     lsu_mem_req_wstrb  byte enables (0 for loads)
//     lsu_mem_req_wdata  lane-shifted store data
//     mem_lsu_resp_vld   response valid (one per request)
//     mem_lsu_resp_rdata full bus word of load data
//     mem_lsu_resp_err   access fault
interface exu_lsu_mem_if #(
    parameter int XLEN = 64
);
    logic                lsu_mem_req_vld;
    logic                mem_lsu_req_rdy;
    logic                lsu_mem_req_wr;
    logic [XLEN-1:0]     lsu_mem_req_addr;
    logic [XLEN/8-1:0]   lsu_mem_req_wstrb;
    logic [XLEN-1:0]     lsu_mem_req_wdata;
    logic                mem_lsu_resp_vld;
    logic [XLEN-1:0]     mem_lsu_resp_rdata;
    logic                mem_lsu_resp_err;

    modport master (
        output lsu_mem_req_vld, lsu_mem_req_wr, lsu_mem_req_addr,
               lsu_mem_req_wstrb, lsu_mem_req_wdata,
        input  mem_lsu_req_rdy, mem_lsu_resp_vld, mem_lsu_resp_rdata,
               mem_lsu_resp_err
    );

    modport slave (
        input  lsu_mem_req_vld, lsu_mem_req_wr, lsu_mem_req_addr,
               lsu_mem_req_wstrb, lsu_mem_req_wdata,
        output mem_lsu_req_rdy, mem_lsu_resp_vld, mem_lsu_resp_rdata,
               mem_lsu_resp_err
    );
endinterface

// File: rtl/exu_lsu_mem.sv
// exu_lsu_mem
//   Bus-based load/store unit. It takes one load or store per issue handshake
//   and runs that instruction over the memory channel in lsu_mem. It reports
//   completion to the ROB and writes load results back to the register file.
//   The unit handles byte-lane alignment, misaligned accesses and access
//   faults. When a flush arrives while a bus transaction is in flight, the
//   unit drains that transaction.
//   Ports:
//     clk, rst_clk            clock and synchronous active-high reset
//     rtu_global_flush        kills the instruction currently held
//     idu_exu_lsu_*           issue handshake and operands
//     exu_idu_lsu_rdy         issue ready (high when idle)
//     lsu_mem                 memory request/response channel (master side)
//     exu_rtu_rob_lsu_*       completion, exception code and faulting address
//     exu_idu_rf_lsu_wb_*     register-file write-back
module exu_lsu_mem #(
    parameter int XLEN   = 64,
    parameter int IID_W  = 5,
    parameter int PREG_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_clk,
    input  logic                 rtu_global_flush,
    input  logic                 idu_exu_lsu_vld,
    output logic                 exu_idu_lsu_rdy,
    input  logic [IID_W-1:0]     idu_exu_lsu_iid,
    input  logic [6:0]           idu_exu_lsu_opcode,
    input  logic [2:0]           idu_exu_lsu_funct3,
    input  logic [XLEN-1:0]      idu_exu_lsu_psrc1_value,
    input  logic [XLEN-1:0]      idu_exu_lsu_psrc2_value,
    input  logic [XLEN-1:0]      idu_exu_lsu_imm,
    input  logic                 idu_exu_lsu_pdst_vld,
    input  logic [PREG_W-1:0]    idu_exu_lsu_pdst,
    exu_lsu_mem_if.master        lsu_mem,
    output logic                 exu_rtu_rob_lsu_complete,
    output logic [IID_W-1:0]     exu_rtu_rob_lsu_iid,
    output logic                 exu_rtu_rob_lsu_expt,
    output logic [3:0]           exu_rtu_rob_lsu_expt_code,
    output logic [XLEN-1:0]      exu_rtu_rob_lsu_badaddr,
    output logic                 exu_idu_rf_lsu_wb_vld,
    output logic [PREG_W-1:0]    exu_idu_rf_lsu_wb_preg,
    output logic [XLEN-1:0]      exu_idu_rf_lsu_wb_data
);
    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RESP, S_DONE, S_DRAIN
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [IID_W-1:0]    r_iid;
    logic [PREG_W-1:0]   r_pdst;
    logic                r_pdst_vld;
    logic [2:0]          r_f3;
    logic [XLEN-1:0]     r_ea;
    logic [XLEN-1:0]     r_sdata;
    logic                r_load;
    logic                r_store;
    logic                r_expt;
    logic [3:0]          r_code;
    logic [XLEN-1:0]     r_rdata;

    logic [XLEN-1:0]     w_ea;
    logic                w_is_load, w_is_store, w_is_mem;
    logic                w_misal, w_illegal, w_accept, w_hs;
    logic [OFF_W-1:0]    w_off;
    logic [STRB_W-1:0]   w_bmask;
    logic [XLEN-1:0]     w_shift, w_left, w_ext;
    logic [7:0]          w_pad;

    // Issue-side decode, evaluated on the incoming operands.
    assign w_ea       = idu_exu_lsu_psrc1_value + idu_exu_lsu_imm;
    assign w_is_load  = (idu_exu_lsu_opcode == 7'b0000011);
    assign w_is_store = (idu_exu_lsu_opcode == 7'b0100011);
    assign w_is_mem   = w_is_load || w_is_store;
    assign w_illegal  = (XLEN == 32) && (idu_exu_lsu_funct3[1:0] == 2'd3);
    assign w_accept   = (r_state == S_IDLE) && idu_exu_lsu_vld && !rtu_global_flush;
    assign w_hs       = (r_state == S_REQ) && lsu_mem.mem_lsu_req_rdy;

    always_comb begin
        w_misal = 1'b0;
        case (idu_exu_lsu_funct3[1:0])
            2'd1:    w_misal = w_ea[0];
            2'd2:    w_misal = (w_ea[1:0] != 2'b00);
            2'd3:    w_misal = (w_ea[2:0] != 3'b000);
            default: w_misal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_nxt = (w_is_mem && !w_misal && !w_illegal) ? S_REQ : S_DONE;
            end
            S_REQ: begin
                if (rtu_global_flush)
                    w_state_nxt = w_hs ? S_DRAIN : S_IDLE;
                else if (w_hs)
                    w_state_nxt = S_RESP;
            end
            S_RESP: begin
                // A flush that lands together with the response consumes that
                // response, so there is nothing left to drain.
                if (lsu_mem.mem_lsu_resp_vld)
                    w_state_nxt = rtu_global_flush ? S_IDLE : S_DONE;
                else if (rtu_global_flush)
                    w_state_nxt = S_DRAIN;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_DRAIN: begin
                if (lsu_mem.mem_lsu_resp_vld)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_clk) begin
            r_state    <= S_IDLE;
            r_iid      <= '0;
            r_pdst     <= '0;
            r_pdst_vld <= 1'b0;
            r_f3       <= '0;
            r_ea       <= '0;
            r_sdata    <= '0;
            r_load     <= 1'b0;
            r_store    <= 1'b0;
            r_expt     <= 1'b0;
            r_code     <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_iid      <= idu_exu_lsu_iid;
                r_pdst     <= idu_exu_lsu_pdst;
                r_pdst_vld <= idu_exu_lsu_pdst_vld;
                r_f3       <= idu_exu_lsu_funct3;
                r_ea       <= w_ea;
                r_sdata    <= idu_exu_lsu_psrc2_value;
                r_load     <= w_is_load;
                r_store    <= w_is_store;
                r_rdata    <= '0;
                // Misalignment takes precedence over the 32-bit D-size fault.
                r_expt     <= w_is_mem && (w_misal || w_illegal);
                if (w_misal)
                    r_code <= w_is_load ? 4'd4 : 4'd6;
                else
                    r_code <= w_is_load ? 4'd5 : 4'd7;
            end
            if ((r_state == S_RESP) && lsu_mem.mem_lsu_resp_vld) begin
                r_rdata <= lsu_mem.mem_lsu_resp_rdata;
                if (lsu_mem.mem_lsu_resp_err) begin
                    r_expt <= 1'b1;
                    r_code <= r_load ? 4'd5 : 4'd7;
                end
            end
        end
    end

    // Request payload is built only from registered state. It therefore stays
    // stable for as long as the request waits for ready.
    assign w_off = r_ea[OFF_W-1:0];

    always_comb begin
        w_bmask = '1;
        case (r_f3[1:0])
            2'd0:    w_bmask = STRB_W'(1);
            2'd1:    w_bmask = STRB_W'(3);
            2'd2:    w_bmask = STRB_W'(15);
            default: w_bmask = '1;
        endcase
    end

    assign lsu_mem.lsu_mem_req_vld   = (r_state == S_REQ);
    assign lsu_mem.lsu_mem_req_wr    = (r_state == S_REQ) && r_store;
    assign lsu_mem.lsu_mem_req_addr  = (r_state == S_REQ) ?
                                       {r_ea[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign lsu_mem.lsu_mem_req_wstrb = ((r_state == S_REQ) && r_store) ? (w_bmask << w_off) : '0;
    assign lsu_mem.lsu_mem_req_wdata = ((r_state == S_REQ) && r_store) ?
                                       (r_sdata << {w_off, 3'b000}) : '0;

    // Load extraction. The addressed bytes are moved to the bottom of the
    // word. They are then pushed to the top and shifted back down, either
    // logically or arithmetically, which truncates and extends in one step.
    always_comb begin
        w_pad = 8'd0;
        case (r_f3[1:0])
            2'd0:    w_pad = 8'(XLEN - 8);
            2'd1:    w_pad = 8'(XLEN - 16);
            2'd2:    w_pad = 8'(XLEN - 32);
            default: w_pad = 8'd0;
        endcase
    end

    assign w_shift = r_rdata >> {w_off, 3'b000};
    assign w_left  = w_shift << w_pad;
    assign w_ext   = r_f3[2] ? (w_left >> w_pad) : $unsigned($signed(w_left) >>> w_pad);

    assign exu_idu_lsu_rdy           = (r_state == S_IDLE);
    assign exu_rtu_rob_lsu_complete  = (r_state == S_DONE) && !rtu_global_flush;
    assign exu_rtu_rob_lsu_iid       = exu_rtu_rob_lsu_complete ? r_iid : '0;
    assign exu_rtu_rob_lsu_expt      = exu_rtu_rob_lsu_complete && r_expt;
    assign exu_rtu_rob_lsu_expt_code = exu_rtu_rob_lsu_expt ? r_code : '0;
    assign exu_rtu_rob_lsu_badaddr   = exu_rtu_rob_lsu_expt ? r_ea : '0;
    assign exu_idu_rf_lsu_wb_vld     = exu_rtu_rob_lsu_complete && r_load && r_pdst_vld && !r_expt;
    assign exu_idu_rf_lsu_wb_preg    = exu_idu_rf_lsu_wb_vld ? r_pdst : '0;
    assign exu_idu_rf_lsu_wb_data    = exu_idu_rf_lsu_wb_vld ? w_ext : '0;
endmodule

// File: doc/exu_lsu_mem.md
# exu_lsu_mem

Parametrised bus-based load/store unit for the EXU: accepts one load or store per issue handshake from the IDU and runs it over a valid/ready memory request channel plus a response channel. Results go to the physical register file write-back port and the ROB completion port. Adds over the previous LSU:

- issue backpressure
- byte-lane alignment
- misalignment and access-fault exceptions
- flush-safe draining of in-flight bus transactions

## Interface

Parameters:
- XLEN, 64, datapath and bus width; legal values 32 or 64
- IID_W, 5, ROB instruction-id width
- PREG_W, 6, physical register index width

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock, all state updates on rising edge
- rst_clk  in  1  synchronous active-high reset
- rtu_global_flush  in  1  kill current instruction
- idu_exu_lsu_vld  in  1  issue valid
- exu_idu_lsu_rdy  out  1  issue ready; equals (state==IDLE)
- idu_exu_lsu_iid  in  IID_W  ROB id
- idu_exu_lsu_opcode  in  7  0000011 load, 0100011 store; anything else completes with no memory access and no write-back
- idu_exu_lsu_funct3  in  3  [1:0] size (B/H/W/D), [2] zero-extend
- idu_exu_lsu_psrc1_value  in  XLEN  base address
- idu_exu_lsu_psrc2_value  in  XLEN  store data
- idu_exu_lsu_imm  in  XLEN  offset
- idu_exu_lsu_pdst_vld  in  1  load has a destination
- idu_exu_lsu_pdst  in  PREG_W  destination preg
- lsu_mem_req_vld  out  1  request valid
- mem_lsu_req_rdy  in  1  request ready
- lsu_mem_req_wr  out  1  1 = store
- lsu_mem_req_addr  out  XLEN  address with low log2(XLEN/8) bits forced to 0
- lsu_mem_req_wstrb  out  XLEN/8  byte enables; 0 for loads
- lsu_mem_req_wdata  out  XLEN  lane-shifted store data
- mem_lsu_resp_vld  in  1  response valid; one per request, never in the request-handshake cycle
- mem_lsu_resp_rdata  in  XLEN  load data, full bus word
- mem_lsu_resp_err  in  1  access fault
- exu_rtu_rob_lsu_complete  out  1  one-cycle completion pulse
- exu_rtu_rob_lsu_iid  out  IID_W  completing id
- exu_rtu_rob_lsu_expt  out  1  exception with completion
- exu_rtu_rob_lsu_expt_code  out  4  codes: 4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault
- exu_rtu_rob_lsu_badaddr  out  XLEN  faulting effective address
- exu_idu_rf_lsu_wb_vld  out  1  write-back pulse
- exu_idu_rf_lsu_wb_preg  out  PREG_W  write-back preg
- exu_idu_rf_lsu_wb_data  out  XLEN  extended load data

## Operation

- Effective address: ea = psrc1 + imm, modulo 2^XLEN, captured at issue with iid, pdst, funct3 and store data.
- Misaligned means any of:
  - H with ea[0] set
  - W with ea[1:0] nonzero
  - D with ea[2:0] nonzero
- With XLEN=32, size D is treated as an access fault (code 5 or 7) and issues no bus request.
- Store lanes:
  - off = ea[log2(XLEN/8)-1:0]
  - wstrb = ((1<<bytes)-1) << off
  - wdata = psrc2 << (8*off)
- Load extraction: rdata >> (8*off), truncated to size. Sign-extended when funct3[2]=0, zero-extended when funct3[2]=1.
- FSM states and transitions:
  - IDLE: accept when vld && !flush. Misaligned, illegal or non-memory opcode → DONE. Otherwise → REQ.
  - REQ: req_vld=1. Handshake → RESP. Flush without handshake → IDLE. Flush with handshake → DRAIN.
  - RESP: resp_vld → DONE (errors are recorded). Flush → DRAIN. Flush together with resp_vld → IDLE, with no completion.
  - DONE: drives completion for one cycle, then → IDLE. Flush in DONE suppresses complete/wb and → IDLE.
  - DRAIN: waits for resp_vld, then → IDLE. Produces no completion or write-back. Flush has no effect.
- Write-back in DONE: wb_vld = load && pdst_vld && !expt.
- Stores already handshaked are not undone by a flush.
- Request payload is held stable while req_vld is high and not yet accepted. The only exception is a flush, which may drop req_vld before the handshake.
- rst_clk has priority over flush; flush has priority over issue.

## Timing

- Reset: state IDLE. All outputs 0 except exu_idu_lsu_rdy, which is 1 in the cycle after reset is sampled.
- Issue accepted at edge T. req_vld is high from T+1.
- Request handshake at cycle H. Response at R ≥ H+1. complete/wb high for cycle R+1. rdy high at R+2.
- Minimum load latency with a zero-wait memory: issue to complete in 3 cycles. Throughput is one instruction per 4 cycles.
- Misaligned or fault-free non-memory op: complete at T+1 with no bus activity. rdy high again at T+2.
- complete, wb_vld and expt are single-cycle pulses. iid, preg, data and badaddr are valid only while complete is high and are 0 otherwise.

## Test plan

- Reset mid-RESP: assert rst_clk during a pending load → next cycle all outputs 0 and rdy=1; a late resp_vld is ignored.
- LB at ea=0x1003 with rdata=0x0000_0000_80FF_0000 (byte lane 3 = 0x80) → wb_data=0xFFFF_FFFF_FFFF_FF80; with funct3=100 (LBU) → 0x80. complete at R+1.
- SH psrc2=0xBEEF, ea=0x2006, XLEN=64 → addr 0x2000, wstrb 0xC0, wdata[63:48]=0xBEEF; complete with no wb.
- LW at ea=0x3002 → no req_vld; complete with expt=1, code 4, badaddr 0x3002 at T+1.
- Flush in RESP after a store handshake, then resp arrives 3 cycles later → no complete pulse, rdy low until the cycle after resp, and a new issue is accepted then.
- mem_lsu_req_rdy held low for 5 cycles → req_vld and payload stable throughout; resp_err=1 on an LD → expt code 5, wb_vld=0.
